gumnut_int_ctrl: RTL and testbench

Interrupt sequencer for the Gumnut core. Sits directly upstream of the interrupt save register: decides when a pending request is taken, pulses that register's write enable to capture PC/C/Z, and redirects fetch to the vector. Also handles the enai/disi/reti instructions, requesting restoration of the saved PC/C/Z on return. Level-sensitive single request line, no nesting.

---
 rtl/gumnut_int_ctrl_pkg.sv | 48 ++++
 rtl/gumnut_int_ctrl_if.sv | 34 +++
 rtl/gumnut_int_ctrl_int_sync.sv | 28 ++
 rtl/gumnut_int_ctrl.sv | 109 ++++++++++
 tb/tb_gumnut_int_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/gumnut_int_ctrl_pkg.sv
// Shared types and defaults for the Gumnut interrupt sequencer.
//   int_state_t    : sequencer state encoding
//   int_flags_t    : Moore output bundle decoded from a state
//   PC_W           : default program counter width
//   VECTOR_DEFAULT : default ISR entry address
package gumnut_int_pkg;

    localparam int unsigned PC_W = 12;
    localparam logic [PC_W-1:0] VECTOR_DEFAULT = 12'h001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TAKE = 2'd1,
        S_ISR  = 2'd2,
        S_RET  = 2'd3
    } int_state_t;

    typedef struct packed {
        logic int_ack;
        logic save_we;
        logic pc_load;
        logic restore;
        logic in_isr;
    } int_flags_t;

    // Moore output decode for a given state.
    function automatic int_flags_t state_flags(input int_state_t s);
        int_flags_t f;
        f = '0;
        case (s)
            S_TAKE: begin
                f.int_ack = 1'b1;
                f.save_we = 1'b1;
                f.pc_load = 1'b1;
            end
            S_ISR: begin
                f.in_isr = 1'b1;
            end
            S_RET: begin
                f.restore = 1'b1;
                f.in_isr  = 1'b1;
            end
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/gumnut_int_ctrl_if.sv
// Core <-> interrupt sequencer signal bundle.
//   master : core side (drives request, decode strobes and pc_i)
//   slave  : sequencer side (drives ack, save/restore and fetch redirect)
interface gumnut_int_ctrl_if #(
    parameter int unsigned PC_W = gumnut_int_pkg::PC_W
);
    logic            int_req;
    logic            inst_boundary;
    logic            enai_i;
    logic            disi_i;
    logic            reti_i;
    logic [PC_W-1:0] pc_i;

    logic            int_ack;
    logic            save_we_o;
    logic [PC_W-1:0] save_pc_o;
    logic            pc_load_o;
    logic [PC_W-1:0] pc_vec_o;
    logic            restore_o;
    logic            int_en_o;
    logic            in_isr_o;

    modport master (
        output int_req, inst_boundary, enai_i, disi_i, reti_i, pc_i,
        input  int_ack, save_we_o, save_pc_o, pc_load_o, pc_vec_o,
               restore_o, int_en_o, in_isr_o
    );

    modport slave (
        input  int_req, inst_boundary, enai_i, disi_i, reti_i, pc_i,
        output int_ack, save_we_o, save_pc_o, pc_load_o, pc_vec_o,
               restore_o, int_en_o, in_isr_o
    );
endinterface

// File: rtl/gumnut_int_ctrl_int_sync.sv
// Two-flop synchronizer for the external interrupt request.
// Only built when INT_SYNC_EN is defined (it is the sole user).
//   clk, rst : clock, async active-high reset (flops clear to 0)
//   cen      : clock enable, both stages advance only when high
//   d        : asynchronous input
//   q        : synchronized output
`ifdef INT_SYNC_EN
module int_sync (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic d,
    output logic q
);
    logic meta;

    // Two stages to let a metastable first stage settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else if (cen) begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule
`endif

// File: rtl/gumnut_int_ctrl.sv
// Gumnut interrupt sequencer: takes a pending level request at an
// instruction boundary, pulses the save-register write enable, redirects
// fetch to VECTOR, and handles enai/disi/reti.
// Ports:
//   clk, rst : clock, async active-high reset
//   cen      : clock enable; all state advances only when high
//   bus      : gumnut_int_ctrl_if.slave (request, decode strobes, pc_i in;
//              ack, save/restore, fetch redirect, status out)
// Build option: INT_SYNC_EN adds a 2-flop synchronizer on int_req
// (take latency +2 cen cycles).
module gumnut_int_ctrl #(
    parameter int unsigned     PC_W   = gumnut_int_pkg::PC_W,
    parameter logic [PC_W-1:0] VECTOR = PC_W'(gumnut_int_pkg::VECTOR_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    gumnut_int_ctrl_if.slave  bus
);
    import gumnut_int_pkg::*;

    int_state_t state_q, state_d;
    logic       int_en_q, int_en_d;
    int_flags_t flags_q, flags_d;
    logic       req_s;
    logic       take;

    // Request path: optionally synchronized.
`ifdef INT_SYNC_EN
    int_sync u_int_sync (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .d   (bus.int_req),
        .q   (req_s)
    );
`else
    assign req_s = bus.int_req;
`endif

    // disi on the boundary cycle blocks the take as well as clearing the enable.
    assign take = int_en_q & req_s & bus.inst_boundary & ~bus.disi_i;

    // Next state, next enable, and output decode of the next state.
    always_comb begin
        state_d  = state_q;
        int_en_d = int_en_q;
        flags_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_d  = S_TAKE;
                    int_en_d = 1'b0;
                end else if (bus.disi_i) begin
                    int_en_d = 1'b0;
                end else if (bus.enai_i) begin
                    int_en_d = 1'b1;
                end
            end
            S_TAKE: begin
                state_d  = S_ISR;
                int_en_d = 1'b0;
            end
            S_ISR: begin
                int_en_d = 1'b0;
                if (bus.reti_i) begin
                    state_d = S_RET;
                end
            end
            S_RET: begin
                state_d  = S_IDLE;
                int_en_d = 1'b1;
            end
            default: begin
                state_d  = S_IDLE;
                int_en_d = 1'b0;
            end
        endcase

        // Registering the decode of state_d gives Moore timing with flop outputs.
        flags_d = state_flags(state_d);
    end

    // State, enable and output registers; frozen while cen is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            int_en_q <= 1'b0;
            flags_q  <= '0;
        end else if (cen) begin
            state_q  <= state_d;
            int_en_q <= int_en_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.int_ack   = flags_q.int_ack;
    assign bus.save_we_o = flags_q.save_we;
    assign bus.pc_load_o = flags_q.pc_load;
    assign bus.restore_o = flags_q.restore;
    assign bus.in_isr_o  = flags_q.in_isr;
    assign bus.int_en_o  = int_en_q;

    // Save register captures the next sequential PC directly.
    assign bus.save_pc_o = bus.pc_i;
    assign bus.pc_vec_o  = VECTOR;

endmodule

// File: tb/tb_gumnut_int_ctrl.sv
// Self-checking bench for gumnut_int_ctrl: vector table driven through a
// scoreboard queue, plus hand-written reset-mid-ISR and take-latency sequences.
module tb_gumnut_int_ctrl;

    localparam int unsigned PC_W = 12;
    localparam logic [PC_W-1:0] VEC = 12'h001;

    // Flag order: {int_ack, save_we, pc_load, restore, int_en, in_isr}
    localparam logic [5:0] F_IDLE0 = 6'b000000;
    localparam logic [5:0] F_IDLE1 = 6'b000010;
    localparam logic [5:0] F_TAKE  = 6'b111000;
    localparam logic [5:0] F_ISR   = 6'b000001;
    localparam logic [5:0] F_RET   = 6'b000101;

    typedef struct {
        logic            cen;
        logic            req;
        logic            bnd;
        logic            enai;
        logic            disi;
        logic            reti;
        logic [PC_W-1:0] pc;
        logic [5:0]      exp_flags;
    } vec_t;

    typedef struct {
        logic [5:0]      flags;
        logic [PC_W-1:0] save_pc;
        int              idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[$];
    exp_t sb[$];

    gumnut_int_ctrl_if #(.PC_W(PC_W)) bif ();

    gumnut_int_ctrl #(.PC_W(PC_W), .VECTOR(VEC)) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [5:0] act_flags();
        return {bif.int_ack, bif.save_we_o, bif.pc_load_o,
                bif.restore_o, bif.int_en_o, bif.in_isr_o};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic rq, input logic b,
                                input logic en, input logic di, input logic rt,
                                input logic [PC_W-1:0] p, input logic [5:0] f);
        vec_t v;
        v.cen = c; v.req = rq; v.bnd = b; v.enai = en; v.disi = di; v.reti = rt;
        v.pc = p; v.exp_flags = f;
        return v;
    endfunction

    task automatic drive(input logic c, input logic rq, input logic b,
                         input logic en, input logic di, input logic rt,
                         input logic [PC_W-1:0] p);
        cen               = c;
        bif.int_req       = rq;
        bif.inst_boundary = b;
        bif.enai_i        = en;
        bif.disi_i        = di;
        bif.reti_i        = rt;
        bif.pc_i          = p;
    endtask

    initial begin
        exp_t e;
        string nm;
        int   lat;
        int   exp_lat;

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h055);
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", 32'(act_flags()), 32'(F_IDLE0));
        check("reset_save_pc", 32'(bif.save_pc_o), 32'h055);
        check("reset_pc_vec", 32'(bif.pc_vec_o), 32'(VEC));
        @(negedge clk);
        rst = 1'b0;

`ifndef INT_SYNC_EN
        //           cen  req  bnd  enai disi reti pc      expected
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 12'h0A0, F_IDLE1)); // enai
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 12'h0A3, F_TAKE));  // take
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 12'h0A4, F_ISR));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 12'h0A5, F_ISR));   // enai ignored in ISR
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 12'h0A6, F_RET));   // reti
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 12'h0A7, F_IDLE1)); // back, enabled
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 12'h0B0, F_TAKE));  // level retake
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 12'h0B1, F_ISR));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 12'h0B2, F_RET));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 12'h0B3, F_IDLE1));
        vecs.push_back(mk(1, 1, 1, 0, 1, 0, 12'h0C0, F_IDLE0)); // disi blocks take
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 12'h0C1, F_IDLE0)); // disabled
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 12'h0C2, F_IDLE1)); // enai
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 12'h0C3, F_TAKE));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 12'h0C4, F_TAKE));  // cen low: frozen
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 12'h0C5, F_TAKE));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 12'h0C6, F_TAKE));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 12'h0C7, F_ISR));   // first cen advances
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 12'h0C8, F_RET));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 12'h0C9, F_IDLE1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 12'h0D0, F_IDLE0)); // enai+disi: disi wins
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 12'h0D1, F_IDLE0)); // reti in idle ignored
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 12'h0D2, F_IDLE1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 12'h0D3, F_IDLE1)); // no boundary: no take
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 12'h0D4, F_TAKE));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 12'h0D5, F_ISR));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].cen, vecs[i].req, vecs[i].bnd, vecs[i].enai,
                  vecs[i].disi, vecs[i].reti, vecs[i].pc);
            e.flags   = vecs[i].exp_flags;
            e.save_pc = vecs[i].pc;
            e.idx     = i;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                nm = $sformatf("vec%0d_flags", e.idx);
                check(nm, 32'(act_flags()), 32'(e.flags));
                nm = $sformatf("vec%0d_save_pc", e.idx);
                check(nm, 32'(bif.save_pc_o), 32'(e.save_pc));
                nm = $sformatf("vec%0d_pc_vec", e.idx);
                check(nm, 32'(bif.pc_vec_o), 32'(VEC));
            end
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Async reset in the middle of an ISR cycle.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0E0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_isr_flags", 32'(act_flags()), 32'(F_IDLE0));
        @(posedge clk);
        #1;
        check("rst_held_no_restore", 32'(bif.restore_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0E1);
        @(posedge clk);
        #1;
        check("post_rst_disabled", 32'(act_flags()), 32'(F_IDLE0));
`endif

        // Take latency from request rise at a held boundary.
`ifdef INT_SYNC_EN
        exp_lat = 3;
`else
        exp_lat = 1;
`endif
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h100);
        @(posedge clk);
        #1;
        check("lat_enabled", 32'(bif.int_en_o), 32'd1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h101);
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bif.int_ack) break;
        end
        check("take_latency", 32'(lat), 32'(exp_lat));
        check("lat_save_we", 32'(bif.save_we_o), 32'd1);
        check("lat_save_pc", 32'(bif.save_pc_o), 32'h101);
        @(posedge clk);
        #1;
        check("lat_in_isr", 32'(bif.in_isr_o), 32'd1);
        check("lat_ack_single", 32'(bif.int_ack), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
